prog_loader: RTL
================

# prog_loader

Byte-serial program loader sitting directly upstream of the FSM controller's programming port. It receives a framed program image over a 3-wire SPI-style slave link (mode 0, MSB first), checks framing and an XOR checksum, and delivers payload bytes one per `prog_enable` strobe on `prog_data`, which feeds the controller's `prog_enable`/`data_in`. Status flags report busy, completion and framing errors to the host and pins.

## Interface
- `MAGIC`, 8'hA5, required first byte of every frame
- `SYNC_STAGES`, 2, flip-flop stages on `sclk`, `cs_n`, `mosi`; minimum 2
- `clock`  in  1  system clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `sclk`  in  1  serial clock, asynchronous to `clock`
- `cs_n`  in  1  frame select, active-low, asynchronous
- `mosi`  in  1  serial data, asynchronous
- `prog_enable`  out  1  one-cycle strobe per delivered payload byte
- `prog_data`  out  8  payload byte, valid while `prog_enable`=1, held otherwise
- `busy`  out  1  frame in progress (state not IDLE/DONE/ERROR)
- `done`  out  1  sticky: last frame passed checksum
- `error`  out  1  sticky: last frame failed (magic, checksum or abort)

## Operation
- Reset: all outputs 0, state IDLE, shift register, bit counter, checksum, length all 0.
- `sclk`, `cs_n`, `mosi` each pass through `SYNC_STAGES` flops; rising edge of synced `sclk` while synced `cs_n`=0 shifts synced `mosi` into bit 0 of an 8-bit shift register (MSB first).
- Bit counter 0..7; on 8th bit a one-cycle internal `byte_valid` fires with the assembled byte; counter wraps to 0.
- Synced `cs_n`=1: bit counter cleared, partial byte discarded.
- FSM states:
  - IDLE: on synced `cs_n` falling -> HEADER; clears `done`, `error`, checksum.
  - HEADER: byte == `MAGIC` -> LENGTH; else -> ERROR.
  - LENGTH: latch byte as `remaining` (8-bit, 0..255); 0 -> CHECK, else -> PAYLOAD.
  - PAYLOAD: each byte: `prog_data`<=byte, `prog_enable`<=1 for one cycle, checksum ^= byte, `remaining`-1; reaching 0 -> CHECK.
  - CHECK: byte == checksum -> DONE (`done`=1); else -> ERROR (`error`=1).
  - DONE/ERROR: further bytes ignored; synced `cs_n` rising -> IDLE, flags keep value.
- Abort: synced `cs_n` rising in HEADER, LENGTH, PAYLOAD or CHECK -> ERROR, `error`=1, then IDLE next cycle; bytes already strobed are not retracted (controller must be reprogrammed).
- Wrong magic enters ERROR immediately; no `prog_enable` pulses for that frame.
- Frame with no bytes (cs_n low then high) -> abort -> `error`=1.
- `busy` = state in {HEADER, LENGTH, PAYLOAD, CHECK}.

## Timing
- Requirement: `clock` >= 4x `sclk`; `sclk` high and low phases each >= 2 `clock` periods.
- Latency: `prog_enable` asserts exactly `SYNC_STAGES`+1 `clock` rising edges after the first edge sampling the raw 8th `sclk` rise of a payload byte.
- `prog_enable` never asserted two consecutive cycles; `prog_data` changes only in the cycle `prog_enable` asserts.
- `done`/`error` update in the same cycle CHECK/abort decision is registered (one cycle after `byte_valid` or synced `cs_n` rise).
- `rst` mid-frame: next cycle IDLE, outputs 0, sync flops cleared; a frame continuing after reset is ignored until synced `cs_n` is seen high then low.
- Simultaneous `byte_valid` and synced `cs_n` rise: byte processed first, then abort/exit evaluated from the resulting state in the next cycle.

## Structure
- Shared package: state enum (IDLE, HEADER, LENGTH, PAYLOAD, CHECK, DONE, ERROR), `MAGIC` default constant, byte width constant.
- Sub-module `spi_byte_rx`: synchronizers, edge detect, shift register, bit counter; outputs `byte_valid`, `byte`, `cs_active`, `cs_rise`, `cs_fall`.
- Top: FSM, length counter, checksum, output registers.

## Test plan
- Frame A5 03 11 22 33 00, cs_n high -> three `prog_enable` pulses with `prog_data` 11, 22, 33 in order; `done`=1, `error`=0, `busy` 0 afterwards.
- Frame A5 02 10 20 31 (expected 30) -> two pulses (10, 20); `error`=1, `done`=0.
- Frame 5A 01 44 44 -> zero pulses, `error`=1 after first byte, remaining bytes ignored.
- Frame A5 04 01 02, cs_n raised after 3 bits of next byte -> pulses 01, 02; `error`=1; partial byte discarded; next valid frame A5 00 00 -> `done`=1, `error`=0.
- `rst` asserted during PAYLOAD of A5 05 ... -> all outputs 0 next cycle; trailing bytes produce no pulses; subsequent A5 01 7E 7E -> one pulse 7E, `done`=1.
- Zero-length A5 00 00 -> no pulses, `done`=1; exact latency of `SYNC_STAGES`+1 checked on every pulse.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-serial program loader.
// Frame layout: MAGIC, LENGTH, LENGTH payload bytes, XOR checksum of the payload.
package prog_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = $clog2(BYTE_W);

    localparam logic [BYTE_W-1:0] MAGIC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_LENGTH,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    function automatic logic state_is_busy(input state_t s);
        return (s == ST_HEADER) || (s == ST_LENGTH) || (s == ST_PAYLOAD) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/prog_loader_spi_byte_rx.sv
// SPI mode-0 slave byte receiver: synchronizes the link, detects edges,
// assembles MSB-first bytes and reports chip-select transitions.
module spi_byte_rx
    import prog_loader_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              cs_active,
    output logic              cs_rise,
    output logic              cs_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic [BYTE_W-1:0]      shreg;
    logic [BYTE_W-1:0]      shifted;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;

    // Clearing cs_n's chain to 0 means a frame still in flight after reset
    // produces no falling edge, so it is ignored until cs_n is seen high again.
    always_ff @(posedge clock) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign cs_active = ~cs_s;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign shifted   = {shreg[BYTE_W-2:0], mosi_s};

    always_ff @(posedge clock) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_s) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shreg <= shifted;
                if (bit_cnt == CNT_LAST) begin
                    byte_valid <= 1'b1;
                    bit_cnt    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // Holds the completed byte during the byte_valid cycle.
    assign byte_data = shreg;

endmodule

// File: rtl/prog_loader.sv
// Program loader: validates a framed image from the SPI byte receiver and
// strobes payload bytes into the controller's programming port.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]  MAGIC       = MAGIC_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       prog_enable,
    output logic [7:0] prog_data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    state_t            state, state_n;
    logic [BYTE_W-1:0] remaining, remaining_n;
    logic [BYTE_W-1:0] checksum, checksum_n;
    logic [BYTE_W-1:0] prog_data_n;
    logic              prog_enable_n;
    logic              done_n;
    logic              error_n;
    logic              exit_pend, exit_pend_n;
    logic              exit_req;

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              cs_active;
    logic              cs_rise;
    logic              cs_fall;

    spi_byte_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clock      (clock),
        .rst        (rst),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .cs_active  (cs_active),
        .cs_rise    (cs_rise),
        .cs_fall    (cs_fall)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            checksum    <= '0;
            prog_enable <= 1'b0;
            prog_data   <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            exit_pend   <= 1'b0;
        end else begin
            state       <= state_n;
            remaining   <= remaining_n;
            checksum    <= checksum_n;
            prog_enable <= prog_enable_n;
            prog_data   <= prog_data_n;
            done        <= done_n;
            error       <= error_n;
            exit_pend   <= exit_pend_n;
        end
    end

    // A cs_n rise coinciding with a byte is deferred one cycle so the byte
    // is consumed first and the exit is judged from the resulting state.
    assign exit_req = cs_rise | exit_pend;

    always_comb begin
        state_n       = state;
        remaining_n   = remaining;
        checksum_n    = checksum;
        prog_enable_n = 1'b0;
        prog_data_n   = prog_data;
        done_n        = done;
        error_n       = error;
        exit_pend_n   = byte_valid & cs_rise;

        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_n     = ST_HEADER;
                    done_n      = 1'b0;
                    error_n     = 1'b0;
                    checksum_n  = '0;
                    remaining_n = '0;
                end
            end
            ST_HEADER: begin
                if (byte_valid) begin
                    if (byte_data == MAGIC) begin
                        state_n = ST_LENGTH;
                    end else begin
                        state_n = ST_ERROR;
                        error_n = 1'b1;
                    end
                end else if (exit_req) begin
                    state_n = ST_ERROR;
                    error_n = 1'b1;
                end
            end
            ST_LENGTH: begin
                if (byte_valid) begin
                    remaining_n = byte_data;
                    state_n     = (byte_data == '0) ? ST_CHECK : ST_PAYLOAD;
                end else if (exit_req) begin
                    state_n = ST_ERROR;
                    error_n = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (byte_valid) begin
                    prog_data_n   = byte_data;
                    prog_enable_n = 1'b1;
                    checksum_n    = checksum ^ byte_data;
                    remaining_n   = remaining - 1'b1;
                    if (remaining == 8'd1) begin
                        state_n = ST_CHECK;
                    end
                end else if (exit_req) begin
                    state_n = ST_ERROR;
                    error_n = 1'b1;
                end
            end
            ST_CHECK: begin
                if (byte_valid) begin
                    if (byte_data == checksum) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_ERROR;
                        error_n = 1'b1;
                    end
                end else if (exit_req) begin
                    state_n = ST_ERROR;
                    error_n = 1'b1;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (!cs_active) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign busy = state_is_busy(state);

endmodule
